// File: rtl/pipe_hazard.sv
// -----------------------------------------------------------------------------
// pipe_hazard -- scoreboard-style RAW / write-depth hazard detector for an
// in-order pipeline.
//
// Every architectural register has a small counter that holds its number of
// issued-but-not-retired writers. An instruction in ID stalls when one of its
// sources has an outstanding writer, or when its destination already has
// MAX_INFLIGHT outstanding writers. Register 0 is hardwired and never tracked.
//
// Optional feature: define HAZARD_WB_BYPASS_EN to let a reader issue in the
// same cycle as the retirement of its last outstanding producer (the regfile
// writes through). Without it the reader issues one cycle later.
//
// Ports
//   clk          in   clock, all state updates on its rising edge
//   rst          in   synchronous active-high reset, clears all counters
//   en           in   global enable, low freezes all state and blocks issue
//   id_valid     in   ID-stage instruction valid
//   id_rs1_used  in   ID instruction reads id_rs1
//   id_rs2_used  in   ID instruction reads id_rs2
//   id_wr        in   ID instruction writes id_rd
//   id_rs1       in   source register 1 address
//   id_rs2       in   source register 2 address
//   id_rd        in   destination register address
//   wb_valid     in   one issued writer retires (committed or squashed)
//   wb_rd        in   destination of the retiring writer
//   ex_flush     in   redirect from EX, kills FE/ID contents
//   stall        out  hold FE and ID this cycle
//   issue        out  ID instruction advances to EX this cycle
//   flush_fe_id  out  squash FE and ID pipeline registers
//   busy         out  some register has outstanding writes
// -----------------------------------------------------------------------------
module pipe_hazard #(
  parameter int REG_ADDR_W   = 5,
  parameter int MAX_INFLIGHT = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  id_valid,
  input  logic                  id_rs1_used,
  input  logic                  id_rs2_used,
  input  logic                  id_wr,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  wb_valid,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic                  ex_flush,
  output logic                  stall,
  output logic                  issue,
  output logic                  flush_fe_id,
  output logic                  busy
);

  localparam int CNT_W = $clog2(MAX_INFLIGHT + 1);
  localparam int NREG  = 2 ** REG_ADDR_W;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_INFLIGHT);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] r_cnt [NREG];

  logic [CNT_W-1:0] w_rs1_cnt;
  logic [CNT_W-1:0] w_rs2_cnt;
  logic [CNT_W-1:0] w_rd_cnt;
  logic             w_rs1_byp;
  logic             w_rs2_byp;
  logic             w_rs1_haz;
  logic             w_rs2_haz;
  logic             w_full;
  logic             w_stall;
  logic             w_issue;
  logic [NREG-1:0]  w_inc;
  logic [NREG-1:0]  w_dec;
  logic             w_busy;

  assign w_rs1_cnt = r_cnt[id_rs1];
  assign w_rs2_cnt = r_cnt[id_rs2];
  assign w_rd_cnt  = r_cnt[id_rd];

`ifdef HAZARD_WB_BYPASS_EN
  // The last outstanding producer retires this cycle and its value is written
  // through the regfile, so the reader may leave ID now.
  assign w_rs1_byp = wb_valid && (wb_rd == id_rs1) && (w_rs1_cnt == CNT_ONE);
  assign w_rs2_byp = wb_valid && (wb_rd == id_rs2) && (w_rs2_cnt == CNT_ONE);
`else
  assign w_rs1_byp = 1'b0;
  assign w_rs2_byp = 1'b0;
`endif

  assign w_rs1_haz = id_rs1_used && (id_rs1 != '0) && (w_rs1_cnt != '0) && !w_rs1_byp;
  assign w_rs2_haz = id_rs2_used && (id_rs2 != '0) && (w_rs2_cnt != '0) && !w_rs2_byp;

  // A retirement to the same destination frees one slot this cycle, so a full
  // counter can accept the new writer (increment and decrement cancel).
  assign w_full = id_wr && (id_rd != '0) && (w_rd_cnt == CNT_MAX) &&
                  !(wb_valid && (wb_rd == id_rd));

  // Flush wins: a killed ID instruction neither stalls nor issues.
  assign w_stall = id_valid && !ex_flush && (w_rs1_haz || w_rs2_haz || w_full);
  assign w_issue = id_valid && !w_stall && !ex_flush && en;

  // NOTE: every variable written in an always_comb gets a default first so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    w_inc  = '0;
    w_dec  = '0;
    w_busy = 1'b0;
    for (int i = 1; i < NREG; i++) begin
      w_inc[i] = w_issue && id_wr && (id_rd == REG_ADDR_W'(i));
      // Retirements against an empty counter (reg 0, or writers that were
      // discarded by a reset) are dropped instead of underflowing.
      w_dec[i] = wb_valid && (wb_rd == REG_ADDR_W'(i)) && (r_cnt[i] != '0);
      w_busy   = w_busy || (r_cnt[i] != '0);
    end
  end

  // NOTE: state is updated with non-blocking assignments so every counter
  // samples the same pre-edge values regardless of statement order.
  // NOTE: the counter array is reset as a whole: it is architectural state
  // (outstanding-writer bookkeeping), not a data memory, and a stale count
  // would deadlock the pipeline.
  always_ff @(posedge clk) begin
    r_cnt[0] <= '0;
    if (rst) begin
      for (int i = 1; i < NREG; i++) begin
        r_cnt[i] <= '0;
      end
    end else if (en) begin
      for (int i = 1; i < NREG; i++) begin
        case ({w_inc[i], w_dec[i]})
          2'b10:   if (r_cnt[i] != CNT_MAX) r_cnt[i] <= r_cnt[i] + CNT_ONE;
          2'b01:   r_cnt[i] <= r_cnt[i] - CNT_ONE;
          default: r_cnt[i] <= r_cnt[i];
        endcase
      end
    end
  end

  assign stall       = w_stall;
  assign issue       = w_issue;
  assign flush_fe_id = ex_flush;
  assign busy        = w_busy;

endmodule

// File: tb/tb_pipe_hazard.sv
// -----------------------------------------------------------------------------
// tb_pipe_hazard -- self-checking bench for pipe_hazard (REG_ADDR_W=5,
// MAX_INFLIGHT=3). A directed vector table, a hand-written RAW sequence whose
// expectations depend on HAZARD_WB_BYPASS_EN, and a randomized run compared
// against a per-register outstanding-writer model.
// Inputs change on the falling edge; outputs are sampled 1 ns later.
// -----------------------------------------------------------------------------
module tb_pipe_hazard;

  localparam int AW  = 5;
  localparam int MAX = 3;
`ifdef HAZARD_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst, en, id_valid, id_rs1_used, id_rs2_used, id_wr;
  logic [AW-1:0] id_rs1, id_rs2, id_rd, wb_rd;
  logic          wb_valid, ex_flush;
  logic          stall, issue, flush_fe_id, busy;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pipe_hazard #(.REG_ADDR_W(AW), .MAX_INFLIGHT(MAX)) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .id_valid    (id_valid),
    .id_rs1_used (id_rs1_used),
    .id_rs2_used (id_rs2_used),
    .id_wr       (id_wr),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_rd       (id_rd),
    .wb_valid    (wb_valid),
    .wb_rd       (wb_rd),
    .ex_flush    (ex_flush),
    .stall       (stall),
    .issue       (issue),
    .flush_fe_id (flush_fe_id),
    .busy        (busy)
  );

  typedef struct {
    logic          rst, en, idv, u1, u2, wr;
    logic [AW-1:0] rs1, rs2, rd;
    logic          wbv;
    logic [AW-1:0] wbrd;
    logic          fl;
    logic          e_stall, e_issue, e_flush, e_busy;
  } vec_t;

  function automatic vec_t mk(input logic r, e, v, u1, u2, w,
                              input int rs1, rs2, rd,
                              input logic wbv, input int wbrd, input logic fl,
                              input logic s, i, f, b);
    vec_t t;
    t.rst = r; t.en = e; t.idv = v; t.u1 = u1; t.u2 = u2; t.wr = w;
    t.rs1 = AW'(rs1); t.rs2 = AW'(rs2); t.rd = AW'(rd);
    t.wbv = wbv; t.wbrd = AW'(wbrd); t.fl = fl;
    t.e_stall = s; t.e_issue = i; t.e_flush = f; t.e_busy = b;
    return t;
  endfunction

  task automatic check(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input vec_t v);
    rst = v.rst; en = v.en; id_valid = v.idv;
    id_rs1_used = v.u1; id_rs2_used = v.u2; id_wr = v.wr;
    id_rs1 = v.rs1; id_rs2 = v.rs2; id_rd = v.rd;
    wb_valid = v.wbv; wb_rd = v.wbrd; ex_flush = v.fl;
  endtask

  // Drive one cycle's inputs on the falling edge and compare the outputs.
  task automatic apply(input string tag, input vec_t v);
    @(negedge clk);
    drive(v);
    #1;
    check({tag, ".stall"}, stall,       v.e_stall);
    check({tag, ".issue"}, issue,       v.e_issue);
    check({tag, ".flush"}, flush_fe_id, v.e_flush);
    check({tag, ".busy"},  busy,        v.e_busy);
  endtask

  vec_t tbl[29];
  vec_t v;

  // Reference model: outstanding writers per register.
  int m_cnt[32];

  initial begin
    //         rst en idv u1 u2 wr rs1 rs2 rd wbv wbrd fl   st is fl bz
    tbl[0]  = mk(0, 1, 1, 0, 0, 1, 0, 0, 7, 0, 0, 0,   0, 1, 0, 0); // first writer rd7
    tbl[1]  = mk(0, 1, 1, 0, 0, 1, 0, 0, 7, 0, 0, 0,   0, 1, 0, 1);
    tbl[2]  = mk(0, 1, 1, 0, 0, 1, 0, 0, 7, 0, 0, 0,   0, 1, 0, 1); // cnt7 -> 3
    tbl[3]  = mk(0, 1, 1, 0, 0, 1, 0, 0, 7, 0, 0, 0,   1, 0, 0, 1); // full
    tbl[4]  = mk(0, 1, 1, 0, 0, 1, 0, 0, 7, 1, 7, 0,   0, 1, 0, 1); // wb+issue, stays 3
    tbl[5]  = mk(0, 1, 1, 0, 0, 1, 0, 0, 7, 0, 0, 0,   1, 0, 0, 1); // still full
    tbl[6]  = mk(0, 1, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0,   0, 1, 0, 1); // r0 reader/writer
    tbl[7]  = mk(0, 1, 1, 1, 0, 0, 7, 0, 0, 0, 0, 1,   0, 0, 1, 1); // flush over hazard
    tbl[8]  = mk(0, 1, 1, 0, 1, 0, 0, 7, 0, 0, 0, 0,   1, 0, 0, 1); // rs2 hazard
    tbl[9]  = mk(0, 0, 1, 0, 0, 1, 0, 0, 3, 1, 7, 0,   0, 0, 0, 1); // en=0 freeze
    tbl[10] = mk(0, 1, 1, 0, 0, 1, 0, 0, 7, 0, 0, 0,   1, 0, 0, 1); // cnt7 still 3
    tbl[11] = mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 7, 0,   0, 0, 0, 1); // -> 2
    tbl[12] = mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 7, 0,   0, 0, 0, 1); // -> 1
    tbl[13] = mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 7, 0,   0, 0, 0, 1); // -> 0
    tbl[14] = mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0);
    tbl[15] = mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 7, 0,   0, 0, 0, 0); // underflow ignored
    tbl[16] = mk(0, 1, 1, 0, 0, 1, 0, 0, 7, 0, 0, 0,   0, 1, 0, 0); // cnt7 -> 1
    tbl[17] = mk(0, 1, 1, 0, 0, 1, 0, 0, 3, 0, 0, 0,   0, 1, 0, 1); // cnt3 -> 1
    tbl[18] = mk(0, 1, 1, 0, 0, 1, 0, 0, 3, 0, 0, 0,   0, 1, 0, 1); // cnt3 -> 2
    tbl[19] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 1); // reset, en=0
    tbl[20] = mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0);
    tbl[21] = mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 3, 0,   0, 0, 0, 0); // stale wb ignored
    tbl[22] = mk(0, 1, 1, 1, 0, 0, 3, 0, 0, 0, 0, 0,   0, 1, 0, 0); // rs1=3 free
    tbl[23] = mk(0, 1, 1, 0, 0, 1, 0, 0, 3, 0, 0, 0,   0, 1, 0, 0);
    tbl[24] = mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 1);
    tbl[25] = mk(1, 1, 1, 0, 0, 1, 0, 0, 5, 0, 0, 0,   0, 1, 0, 1); // rst beats issue
    tbl[26] = mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0);
    tbl[27] = mk(0, 1, 1, 0, 0, 1, 0, 0, 9, 0, 0, 1,   0, 0, 1, 0); // killed writer
    tbl[28] = mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0);

    // Initial reset.
    v = mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(v);
    repeat (2) @(posedge clk);

    for (int i = 0; i < 29; i++) begin
      apply($sformatf("tbl[%0d]", i), tbl[i]);
    end

    // Writer rd=5 then reader rs1=5: stalls until its producer retires.
    apply("raw.wr",   mk(0, 1, 1, 0, 0, 1, 0, 0, 5, 0, 0, 0, 0, 1, 0, 0));
    apply("raw.rd0",  mk(0, 1, 1, 1, 0, 0, 5, 0, 0, 0, 0, 0, 1, 0, 0, 1));
    apply("raw.rd1",  mk(0, 1, 1, 1, 0, 0, 5, 0, 0, 0, 0, 0, 1, 0, 0, 1));
    apply("raw.wb",   mk(0, 1, 1, 1, 0, 0, 5, 0, 0, 1, 5, 0, !BYP, BYP, 0, 1));
    apply("raw.post", mk(0, 1, 1, 1, 0, 0, 5, 0, 0, 0, 0, 0, 0, 1, 0, 0));

    // Randomized run against the model; the first cycle is a reset.
    for (int c = 0; c < 3000; c++) begin
      logic e_stall, e_issue, e_busy, h1, h2, full, b1, b2;
      int live[$];
      @(negedge clk);
      rst         = (c == 0) || ($urandom_range(0, 199) == 0);
      en          = ($urandom_range(0, 9) != 0);
      id_valid    = ($urandom_range(0, 3) != 0);
      id_rs1_used = $urandom_range(0, 1) == 1;
      id_rs2_used = $urandom_range(0, 1) == 1;
      id_wr       = $urandom_range(0, 2) != 0;
      id_rs1      = AW'($urandom_range(0, 5));
      id_rs2      = AW'($urandom_range(0, 5));
      id_rd       = AW'($urandom_range(0, 5));
      ex_flush    = ($urandom_range(0, 11) == 0);
      for (int r = 1; r < 32; r++) if (m_cnt[r] > 0) live.push_back(r);
      wb_valid    = ($urandom_range(0, 2) == 0);
      if (live.size() > 0 && $urandom_range(0, 7) != 0)
        wb_rd = AW'(live[$urandom_range(0, live.size() - 1)]);
      else
        wb_rd = AW'($urandom_range(0, 5));
      #1;
      b1 = BYP && wb_valid && (int'(wb_rd) == int'(id_rs1)) && (m_cnt[id_rs1] == 1);
      b2 = BYP && wb_valid && (int'(wb_rd) == int'(id_rs2)) && (m_cnt[id_rs2] == 1);
      h1 = id_rs1_used && (id_rs1 != 0) && (m_cnt[id_rs1] > 0) && !b1;
      h2 = id_rs2_used && (id_rs2 != 0) && (m_cnt[id_rs2] > 0) && !b2;
      full = id_wr && (id_rd != 0) && (m_cnt[id_rd] == MAX) &&
             !(wb_valid && wb_rd == id_rd);
      e_stall = id_valid && !ex_flush && (h1 || h2 || full);
      e_issue = id_valid && !e_stall && !ex_flush && en;
      e_busy  = 1'b0;
      for (int r = 0; r < 32; r++) if (m_cnt[r] > 0) e_busy = 1'b1;
      check($sformatf("rnd[%0d].stall", c), stall,       e_stall);
      check($sformatf("rnd[%0d].issue", c), issue,       e_issue);
      check($sformatf("rnd[%0d].flush", c), flush_fe_id, ex_flush);
      check($sformatf("rnd[%0d].busy",  c), busy,        e_busy);
      // State after the coming rising edge.
      if (rst) begin
        for (int r = 0; r < 32; r++) m_cnt[r] = 0;
      end else if (en) begin
        if (wb_valid && wb_rd != 0 && m_cnt[wb_rd] > 0) m_cnt[wb_rd]--;
        if (e_issue && id_wr && id_rd != 0) m_cnt[id_rd]++;
      end
    end

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_hazard.md
PIPE_HAZARD -- requirements
Module: pipe_hazard

Interface
REQ-001 SHALL have parameter REG_ADDR_W, default 5, register address width (2**REG_ADDR_W architectural registers).
REQ-002 SHALL have parameter MAX_INFLIGHT, default 3, maximum outstanding writes per register; counter width CNT_W = clog2(MAX_INFLIGHT+1).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port en  input  1  global enable; low freezes all state.
REQ-006 SHALL have ports id_valid, id_rs1_used, id_rs2_used, id_wr  input  1 each  ID-stage instruction valid, source-use flags, destination-write flag.
REQ-007 SHALL have ports id_rs1, id_rs2, id_rd  input  REG_ADDR_W each  ID-stage source and destination addresses.
REQ-008 SHALL have port wb_valid  input  1  one retirement of an issued writer (committed or squashed).
REQ-009 SHALL have port wb_rd  input  REG_ADDR_W  destination of the retiring writer.
REQ-010 SHALL have port ex_flush  input  1  redirect from EX; kills FE/ID contents.
REQ-011 SHALL have port stall  output  1  hold FE and ID this cycle.
REQ-012 SHALL have port issue  output  1  ID instruction advances to EX this cycle.
REQ-013 SHALL have port flush_fe_id  output  1  squash FE and ID pipeline registers.
REQ-014 SHALL have port busy  output  1  any register has outstanding writes.

Function
REQ-015 SHALL hold one CNT_W-bit outstanding-write counter per register; register 0 counter SHALL be constantly zero.
REQ-016 SHALL compute hazard combinationally: rsN_haz = id_rsN_used AND rsN != 0 AND cnt[rsN] != 0 AND NOT bypass(rsN) (bypass per REQ-026/027).
REQ-017 SHALL compute full = id_wr AND id_rd != 0 AND cnt[id_rd] == MAX_INFLIGHT AND NOT (wb_valid AND wb_rd == id_rd).
REQ-018 SHALL drive stall = id_valid AND NOT ex_flush AND (rs1_haz OR rs2_haz OR full); no latency.
REQ-019 SHALL drive issue = id_valid AND NOT stall AND NOT ex_flush AND en.
REQ-020 SHALL drive flush_fe_id = ex_flush; flush wins over stall; killed ID instruction SHALL NOT increment any counter.
REQ-021 SHALL, when en=1: cnt[r] += 1 if issue AND id_wr AND id_rd==r (r!=0); cnt[r] -= 1 if wb_valid AND wb_rd==r; both same cycle SHALL leave cnt[r] unchanged.
REQ-022 SHALL ignore wb_valid when wb_rd==0 or cnt[wb_rd]==0 (no underflow); counters SHALL never exceed MAX_INFLIGHT.
REQ-023 SHALL, when en=0, hold all counters; outputs still computed, issue forced 0.
REQ-024 SHALL drive busy = OR of all counters nonzero, registered-state based (not next-state).
REQ-025 SHALL rely on downstream asserting wb_valid exactly once per issued writer, including writers squashed by ex_flush.

Configuration
REQ-026 SHALL, with macro HAZARD_WB_BYPASS_EN defined, treat bypass(rs) = wb_valid AND wb_rd==rs AND cnt[rs]==1 (regfile write-through), so the reading instruction issues in the retire cycle.
REQ-027 SHALL, without HAZARD_WB_BYPASS_EN, treat bypass as 0; reader issues the cycle after the counter reaches zero (one extra stall cycle).

Reset
REQ-028 SHALL, on rst=1 at clock edge, clear all counters to 0 regardless of en; rst has priority over issue and wb_valid.
REQ-029 SHALL after reset present stall=0, issue=id_valid AND NOT ex_flush AND en, flush_fe_id=ex_flush, busy=0.
REQ-030 SHALL, on reset mid-operation, discard outstanding counts; later wb_valid for pre-reset writers SHALL be ignored per REQ-022.

Verification
REQ-031 SHALL cover: issue writer rd=5, next cycle reader rs1=5 -> stall=1 until wb_valid rd=5; with bypass stall drops in WB cycle, without one cycle later.
REQ-032 SHALL cover: three writers to rd=7 back-to-back (MAX_INFLIGHT=3), fourth writer rd=7 -> stall=1 until one wb_valid rd=7; same-cycle wb and issue keeps cnt[7]=3.
REQ-033 SHALL cover: reader rs1=0 rs2=0 with all counters nonzero elsewhere, writer rd=0 -> never stalls, busy unaffected by rd=0.
REQ-034 SHALL cover: ex_flush=1 while stalled on hazard -> stall=0, flush_fe_id=1, issue=0, counters unchanged.
REQ-035 SHALL cover: en=0 with id_valid=1, wb_valid=1 -> issue=0, counters frozen; en=1 resumes.
REQ-036 SHALL cover: rst=1 with cnt[3]=2 -> busy=0 next cycle; subsequent wb_valid rd=3 leaves cnt[3]=0.
